// File: rtl/video_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : video_frame_ctrl
// Purpose  : Frame-level sequencer for the video effects IP. Tracks frame
//            boundaries on the Avalon-ST sink handshake. Freezes the register
//            configuration for the duration of a frame. Provides pause,
//            end-of-frame interrupt, and frame-length / framing error flags.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk              rising-edge clock
//   reset            asynchronous active-low reset
//   cfg_ctrl         [0] pause_req, [1] irq_enable
//   cfg_effect       [4:0] effect, [9:8] delete_rgb, [17:16] quantif_level
//   cfg_key          [31:16] color_key, [15:0] color_mask
//   cfg_subst        [15:0] color_substitute
//   irq_clr          pulse, clears the pending interrupt
//   err_clr          pulse, clears err_len and err_sop
//   snk_valid/ready  sink handshake; a beat is valid & ready
//   snk_sop/eop      packet delimiters of the sink stream
//   stream_en        0 while paused (top gates ready/valid with it)
//   act_*            configuration frozen for the current frame
//   irq              pending interrupt gated by irq_enable
//   paused/in_frame  state indications
//   frame_count      completed frames (wrapping)
//   pix_count        beats of the current (or last completed) frame
//   err_len/err_sop  sticky error flags
// ============================================================================
module video_frame_ctrl #(
   parameter int FRAME_PIXELS = 76800,
   parameter int PIX_W        = 17,
   parameter int CNT_W        = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       cfg_ctrl,
   input  logic [31:0]       cfg_effect,
   input  logic [31:0]       cfg_key,
   input  logic [31:0]       cfg_subst,
   input  logic              irq_clr,
   input  logic              err_clr,
   input  logic              snk_valid,
   input  logic              snk_ready,
   input  logic              snk_sop,
   input  logic              snk_eop,
   output logic              stream_en,
   output logic [4:0]        act_effect,
   output logic [1:0]        act_delete_rgb,
   output logic [1:0]        act_quantif,
   output logic [15:0]       act_color_key,
   output logic [15:0]       act_color_mask,
   output logic [15:0]       act_color_subst,
   output logic              irq,
   output logic              paused,
   output logic              in_frame,
   output logic [CNT_W-1:0]  frame_count,
   output logic [PIX_W-1:0]  pix_count,
   output logic              err_len,
   output logic              err_sop
);

   localparam logic [PIX_W-1:0] c_FRAME_PIXELS = PIX_W'(FRAME_PIXELS);
   localparam logic [PIX_W-1:0] c_ONE          = PIX_W'(1);
   localparam logic [PIX_W-1:0] c_PIX_MAX      = '1;
   localparam logic [CNT_W-1:0] c_CNT_ONE      = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_WAIT_SOP = 2'd0,
      ST_IN_FRAME = 2'd1,
      ST_PAUSED   = 2'd2
   } state_t;

   state_t             r_state;
   logic               r_in_frame;
   logic [PIX_W-1:0]   r_pix;
   logic [CNT_W-1:0]   r_frames;
   logic               r_pending;
   logic               r_err_len;
   logic               r_err_sop;
   logic [4:0]         r_effect;
   logic [1:0]         r_delete_rgb;
   logic [1:0]         r_quantif;
   logic [15:0]        r_color_key;
   logic [15:0]        r_color_mask;
   logic [15:0]        r_color_subst;

   logic               w_beat;
   logic               w_pause_req;
   logic               w_irq_en;
   logic [PIX_W-1:0]   w_pix_inc;
   state_t             w_state_nxt;
   logic [PIX_W-1:0]   w_pix_nxt;
   logic               w_frame_end;
   logic [PIX_W-1:0]   w_frame_len;
   logic               w_sop_err;
   logic               w_len_err;

   // Register fields that have no function in this block.
   logic               w_unused_cfg;
   assign w_unused_cfg = ^{cfg_ctrl[31:2], cfg_effect[31:18], cfg_effect[15:10],
                           cfg_effect[7:5], cfg_subst[31:16]};

   assign w_beat      = snk_valid & snk_ready;
   assign w_pause_req = cfg_ctrl[0];
   assign w_irq_en    = cfg_ctrl[1];

   // Saturating increment: an over-long frame parks at the maximum count and
   // still flags a length error at its EOP.
   assign w_pix_inc = (r_pix == c_PIX_MAX) ? r_pix : r_pix + c_ONE;

   // ------------------------------------------------------------------------
   // Next-state / event decode
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_pix_nxt   = r_pix;
      w_frame_end = 1'b0;
      w_frame_len = r_pix;
      w_sop_err   = 1'b0;

      case (r_state)
         ST_WAIT_SOP: begin
            if (w_beat) begin
               if (snk_sop) begin
                  if (snk_eop) begin
                     // Single-beat frame: closes immediately.
                     w_frame_end = 1'b1;
                     w_frame_len = c_ONE;
                  end else begin
                     w_state_nxt = ST_IN_FRAME;
                     w_pix_nxt   = c_ONE;
                  end
               end else begin
                  // Data outside a frame is dropped.
                  w_sop_err = 1'b1;
               end
            end else if (w_pause_req) begin
               // A SOP beat takes precedence over a pause request.
               w_state_nxt = ST_PAUSED;
            end
         end

         ST_IN_FRAME: begin
            if (w_beat) begin
               if (snk_sop) begin
                  // Missing EOP: the new SOP restarts the frame.
                  w_sop_err = 1'b1;
                  if (snk_eop) begin
                     w_frame_end = 1'b1;
                     w_frame_len = c_ONE;
                     w_state_nxt = ST_WAIT_SOP;
                  end else begin
                     w_pix_nxt   = c_ONE;
                  end
               end else if (snk_eop) begin
                  w_frame_end = 1'b1;
                  w_frame_len = w_pix_inc;
                  w_state_nxt = ST_WAIT_SOP;
               end else begin
                  w_pix_nxt   = w_pix_inc;
               end
            end
         end

         ST_PAUSED: begin
            if (!w_pause_req) begin
               w_state_nxt = ST_WAIT_SOP;
            end
         end

         default: begin
            w_state_nxt = ST_WAIT_SOP;
         end
      endcase

      // The completed length stays visible until the next SOP.
      if (w_frame_end) begin
         w_pix_nxt = w_frame_len;
      end
   end

   assign w_len_err = w_frame_end && (w_frame_len != c_FRAME_PIXELS);

   // ------------------------------------------------------------------------
   // State and registered outputs
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= ST_WAIT_SOP;
         r_in_frame    <= 1'b0;
         r_pix         <= '0;
         r_frames      <= '0;
         r_pending     <= 1'b0;
         r_err_len     <= 1'b0;
         r_err_sop     <= 1'b0;
         r_effect      <= '0;
         r_delete_rgb  <= '0;
         r_quantif     <= '0;
         r_color_key   <= '0;
         r_color_mask  <= '0;
         r_color_subst <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_in_frame <= (w_state_nxt == ST_IN_FRAME);
         r_pix      <= w_pix_nxt;

         // Configuration tracks the registers everywhere except inside a
         // frame, so the values sampled with the SOP beat stay frozen.
         if (r_state != ST_IN_FRAME) begin
            r_effect      <= cfg_effect[4:0];
            r_delete_rgb  <= cfg_effect[9:8];
            r_quantif     <= cfg_effect[17:16];
            r_color_key   <= cfg_key[31:16];
            r_color_mask  <= cfg_key[15:0];
            r_color_subst <= cfg_subst[15:0];
         end

         if (w_frame_end) begin
            r_frames <= r_frames + c_CNT_ONE;
         end

         // Set wins over a same-cycle clear.
         r_pending <= (w_frame_end & w_irq_en) | (r_pending & ~irq_clr);
         r_err_len <= w_len_err | (r_err_len & ~err_clr);
         r_err_sop <= w_sop_err | (r_err_sop & ~err_clr);
      end
   end

   assign stream_en       = (r_state != ST_PAUSED);
   assign paused          = (r_state == ST_PAUSED);
   assign in_frame        = r_in_frame;
   assign irq             = r_pending & w_irq_en;
   assign frame_count     = r_frames;
   assign pix_count       = r_pix;
   assign err_len         = r_err_len;
   assign err_sop         = r_err_sop;
   assign act_effect      = r_effect;
   assign act_delete_rgb  = r_delete_rgb;
   assign act_quantif     = r_quantif;
   assign act_color_key   = r_color_key;
   assign act_color_mask  = r_color_mask;
   assign act_color_subst = r_color_subst;

endmodule
`default_nettype wire

// File: tb/tb_video_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_frame_ctrl
// Purpose  : Self-checking bench for video_frame_ctrl (FRAME_PIXELS=4).
//            Directed vector table, hand-written corner sequences and random
//            traffic checked against a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_video_frame_ctrl;

   localparam int FP = 4;
   localparam int PW = 3;
   localparam int CW = 4;
   localparam int PIX_MAX = (1 << PW) - 1;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [31:0]   cfg_ctrl = '0, cfg_effect = '0, cfg_key = '0, cfg_subst = '0;
   logic          irq_clr = 1'b0, err_clr = 1'b0;
   logic          snk_valid = 1'b0, snk_ready = 1'b1, snk_sop = 1'b0, snk_eop = 1'b0;
   logic          stream_en, irq, paused, in_frame, err_len, err_sop;
   logic [4:0]    act_effect;
   logic [1:0]    act_delete_rgb, act_quantif;
   logic [15:0]   act_color_key, act_color_mask, act_color_subst;
   logic [CW-1:0] frame_count;
   logic [PW-1:0] pix_count;

   video_frame_ctrl #(.FRAME_PIXELS(FP), .PIX_W(PW), .CNT_W(CW)) u_dut (
      .clk(clk), .reset(reset),
      .cfg_ctrl(cfg_ctrl), .cfg_effect(cfg_effect), .cfg_key(cfg_key), .cfg_subst(cfg_subst),
      .irq_clr(irq_clr), .err_clr(err_clr),
      .snk_valid(snk_valid), .snk_ready(snk_ready), .snk_sop(snk_sop), .snk_eop(snk_eop),
      .stream_en(stream_en), .act_effect(act_effect), .act_delete_rgb(act_delete_rgb),
      .act_quantif(act_quantif), .act_color_key(act_color_key),
      .act_color_mask(act_color_mask), .act_color_subst(act_color_subst),
      .irq(irq), .paused(paused), .in_frame(in_frame), .frame_count(frame_count),
      .pix_count(pix_count), .err_len(err_len), .err_sop(err_sop)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- reference model (frame-level view) ----------------
   // m_st: 0 = waiting for SOP, 1 = inside a frame, 2 = paused
   int          m_st, m_len, m_fc;
   bit          m_pend, m_elen, m_esop;
   logic [31:0] m_eff, m_key, m_subst;

   task automatic model_reset();
      m_st = 0; m_len = 0; m_fc = 0;
      m_pend = 0; m_elen = 0; m_esop = 0;
      m_eff = '0; m_key = '0; m_subst = '0;
   endtask

   task automatic model_step();
      bit beat;
      bit fe;
      bit s_len;
      bit s_sop;
      int flen;
      beat = snk_valid & snk_ready;
      fe = 0; s_len = 0; s_sop = 0; flen = 0;
      if (m_st != 1) begin
         m_eff = cfg_effect; m_key = cfg_key; m_subst = cfg_subst;
      end
      case (m_st)
         0: begin
            if (beat) begin
               if (snk_sop && snk_eop) begin fe = 1; flen = 1; end
               else if (snk_sop) begin m_st = 1; m_len = 1; end
               else s_sop = 1;
            end else if (cfg_ctrl[0]) m_st = 2;
         end
         1: begin
            if (beat) begin
               if (snk_sop) s_sop = 1;
               if (snk_eop) begin
                  fe = 1; flen = snk_sop ? 1 : m_len + 1; m_st = 0;
               end else begin
                  m_len = snk_sop ? 1 : m_len + 1;
               end
            end
         end
         default: if (!cfg_ctrl[0]) m_st = 0;
      endcase
      if (fe) begin
         m_fc  = (m_fc + 1) % (1 << CW);
         m_len = flen;
         s_len = (flen != FP);
      end
      m_pend = (fe & cfg_ctrl[1]) | (m_pend & ~irq_clr);
      m_elen = s_len | (m_elen & ~err_clr);
      m_esop = s_sop | (m_esop & ~err_clr);
   endtask

   task automatic check_model();
      chk("stream_en", 32'(stream_en), 32'(m_st != 2));
      chk("paused",    32'(paused),    32'(m_st == 2));
      chk("in_frame",  32'(in_frame),  32'(m_st == 1));
      chk("act_effect", 32'(act_effect), 32'(m_eff[4:0]));
      chk("act_delete_rgb", 32'(act_delete_rgb), 32'(m_eff[9:8]));
      chk("act_quantif", 32'(act_quantif), 32'(m_eff[17:16]));
      chk("act_color_key", 32'(act_color_key), 32'(m_key[31:16]));
      chk("act_color_mask", 32'(act_color_mask), 32'(m_key[15:0]));
      chk("act_color_subst", 32'(act_color_subst), 32'(m_subst[15:0]));
      chk("irq", 32'(irq), 32'(m_pend & cfg_ctrl[1]));
      chk("frame_count", 32'(frame_count), 32'(m_fc));
      chk("pix_count", 32'(pix_count), 32'((m_len > PIX_MAX) ? PIX_MAX : m_len));
      chk("err_len", 32'(err_len), 32'(m_elen));
      chk("err_sop", 32'(err_sop), 32'(m_esop));
   endtask

   // Inputs are already set; advance one clock and compare away from the edge.
   task automatic step();
      model_step();
      @(posedge clk);
      #1;
      check_model();
   endtask

   task automatic beat(input bit s, input bit e);
      snk_valid = 1'b1; snk_sop = s; snk_eop = e;
      step();
   endtask

   task automatic idle();
      snk_valid = 1'b0; snk_sop = 1'b0; snk_eop = 1'b0;
      step();
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_stream_en"}, 32'(stream_en), 32'd1);
      chk({tag, "_paused"},    32'(paused),    32'd0);
      chk({tag, "_in_frame"},  32'(in_frame),  32'd0);
      chk({tag, "_act"}, {act_effect, act_delete_rgb, act_quantif, 23'd0}, 32'd0);
      chk({tag, "_act_key"}, {act_color_key, act_color_mask}, 32'd0);
      chk({tag, "_act_subst"}, 32'(act_color_subst), 32'd0);
      chk({tag, "_irq"}, 32'(irq), 32'd0);
      chk({tag, "_frame_count"}, 32'(frame_count), 32'd0);
      chk({tag, "_pix_count"}, 32'(pix_count), 32'd0);
      chk({tag, "_err"}, {30'd0, err_len, err_sop}, 32'd0);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      bit v, s, e;
      logic [4:0] eff;
      bit iclr, eclr;
      bit x_in;
      logic [4:0] x_eff;
      logic [CW-1:0] x_fc;
      logic [PW-1:0] x_pix;
      bit x_irq, x_el, x_es;
   } vec_t;

   function automatic vec_t mk(input int v, s, e, eff, iclr, eclr,
                               input int xin, xeff, xfc, xpix, xirq, xel, xes);
      vec_t r;
      r.v = v[0]; r.s = s[0]; r.e = e[0]; r.eff = eff[4:0];
      r.iclr = iclr[0]; r.eclr = eclr[0];
      r.x_in = xin[0]; r.x_eff = xeff[4:0]; r.x_fc = xfc[CW-1:0];
      r.x_pix = xpix[PW-1:0]; r.x_irq = xirq[0]; r.x_el = xel[0]; r.x_es = xes[0];
      return r;
   endfunction

   vec_t tbl[28];

   initial begin
      //          v s e eff   ic ec | in eff    fc pix irq el es
      tbl[0]  = mk(0,0,0,'h04, 0,0,   0,'h04, 0, 0, 0, 0, 0);
      tbl[1]  = mk(1,1,0,'h04, 0,0,   1,'h04, 0, 1, 0, 0, 0);
      tbl[2]  = mk(1,0,0,'h04, 0,0,   1,'h04, 0, 2, 0, 0, 0);
      tbl[3]  = mk(1,0,0,'h04, 0,0,   1,'h04, 0, 3, 0, 0, 0);
      tbl[4]  = mk(1,0,1,'h04, 0,0,   0,'h04, 1, 4, 1, 0, 0);
      tbl[5]  = mk(0,0,0,'h04, 1,0,   0,'h04, 1, 4, 0, 0, 0);
      tbl[6]  = mk(1,1,0,'h01, 0,0,   1,'h01, 1, 1, 0, 0, 0);
      tbl[7]  = mk(1,0,0,'h01, 0,0,   1,'h01, 1, 2, 0, 0, 0);
      tbl[8]  = mk(1,0,0,'h10, 0,0,   1,'h01, 1, 3, 0, 0, 0);
      tbl[9]  = mk(1,0,1,'h10, 0,0,   0,'h01, 2, 4, 1, 0, 0);
      tbl[10] = mk(0,0,0,'h10, 1,0,   0,'h10, 2, 4, 0, 0, 0);
      tbl[11] = mk(1,1,0,'h10, 0,0,   1,'h10, 2, 1, 0, 0, 0);
      tbl[12] = mk(1,0,0,'h10, 0,0,   1,'h10, 2, 2, 0, 0, 0);
      tbl[13] = mk(1,0,1,'h10, 0,0,   0,'h10, 3, 3, 1, 1, 0);
      tbl[14] = mk(0,0,0,'h10, 1,0,   0,'h10, 3, 3, 0, 1, 0);
      tbl[15] = mk(1,1,0,'h10, 0,0,   1,'h10, 3, 1, 0, 1, 0);
      tbl[16] = mk(1,0,1,'h10, 0,1,   0,'h10, 4, 2, 1, 1, 0);
      tbl[17] = mk(0,0,0,'h10, 1,1,   0,'h10, 4, 2, 0, 0, 0);
      tbl[18] = mk(1,1,0,'h10, 0,0,   1,'h10, 4, 1, 0, 0, 0);
      tbl[19] = mk(1,0,0,'h10, 0,0,   1,'h10, 4, 2, 0, 0, 0);
      tbl[20] = mk(1,1,0,'h10, 0,0,   1,'h10, 4, 1, 0, 0, 1);
      tbl[21] = mk(1,0,0,'h10, 0,0,   1,'h10, 4, 2, 0, 0, 1);
      tbl[22] = mk(1,0,0,'h10, 0,0,   1,'h10, 4, 3, 0, 0, 1);
      tbl[23] = mk(1,0,1,'h10, 0,0,   0,'h10, 5, 4, 1, 0, 1);
      tbl[24] = mk(0,0,0,'h10, 1,0,   0,'h10, 5, 4, 0, 0, 1);
      tbl[25] = mk(1,1,1,'h10, 0,0,   0,'h10, 6, 1, 1, 1, 1);
      tbl[26] = mk(0,0,0,'h10, 1,1,   0,'h10, 6, 1, 0, 0, 0);
      tbl[27] = mk(1,0,0,'h10, 0,0,   0,'h10, 6, 1, 0, 0, 1);

      // ---- reset state ----
      model_reset();
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset("rst");
      reset = 1'b1;

      // ---- directed table ----
      cfg_ctrl  = 32'h2;
      cfg_key   = 32'hA5A5_0F0F;
      cfg_subst = 32'h0000_1234;
      for (int i = 0; i < 28; i++) begin
         snk_valid = tbl[i].v; snk_sop = tbl[i].s; snk_eop = tbl[i].e;
         cfg_effect = {27'd0, tbl[i].eff};
         irq_clr = tbl[i].iclr; err_clr = tbl[i].eclr;
         step();
         chk($sformatf("tbl%0d_in_frame", i), 32'(in_frame), 32'(tbl[i].x_in));
         chk($sformatf("tbl%0d_act_effect", i), 32'(act_effect), 32'(tbl[i].x_eff));
         chk($sformatf("tbl%0d_frame_count", i), 32'(frame_count), 32'(tbl[i].x_fc));
         chk($sformatf("tbl%0d_pix_count", i), 32'(pix_count), 32'(tbl[i].x_pix));
         chk($sformatf("tbl%0d_irq", i), 32'(irq), 32'(tbl[i].x_irq));
         chk($sformatf("tbl%0d_err_len", i), 32'(err_len), 32'(tbl[i].x_el));
         chk($sformatf("tbl%0d_err_sop", i), 32'(err_sop), 32'(tbl[i].x_es));
      end
      irq_clr = 1'b0; err_clr = 1'b0;

      // ---- pause requested inside a frame ----
      beat(1, 0);
      cfg_ctrl = 32'h3;
      beat(0, 0);
      chk("pause_mid_stream_en", 32'(stream_en), 32'd1);
      beat(0, 0);
      chk("pause_mid2_paused", 32'(paused), 32'd0);
      beat(0, 1);
      chk("pause_eop_stream_en", 32'(stream_en), 32'd1);
      idle();
      chk("pause_taken_paused", 32'(paused), 32'd1);
      chk("pause_taken_stream_en", 32'(stream_en), 32'd0);
      snk_ready = 1'b0;
      idle();
      chk("pause_hold_paused", 32'(paused), 32'd1);
      cfg_ctrl = 32'h2;
      idle();
      snk_ready = 1'b1;
      chk("unpause_stream_en", 32'(stream_en), 32'd1);
      chk("unpause_paused", 32'(paused), 32'd0);

      // ---- SOP beat together with pause_req: frame wins ----
      cfg_ctrl = 32'h3;
      beat(1, 0);
      chk("sop_vs_pause_in_frame", 32'(in_frame), 32'd1);
      chk("sop_vs_pause_paused", 32'(paused), 32'd0);
      beat(0, 1);
      idle();
      chk("sop_vs_pause_later", 32'(paused), 32'd1);
      snk_ready = 1'b0;
      cfg_ctrl = 32'h2;
      idle();
      snk_ready = 1'b1;

      // ---- over-long frame: pixel count saturates ----
      beat(1, 0);
      for (int i = 0; i < 9; i++) beat(0, 0);
      chk("sat_pix_count", 32'(pix_count), 32'(PIX_MAX));
      beat(0, 1);
      chk("sat_eop_pix", 32'(pix_count), 32'(PIX_MAX));
      chk("sat_eop_err_len", 32'(err_len), 32'd1);

      // ---- reset in the middle of a frame ----
      beat(1, 0);
      beat(0, 0);
      chk("midrst_pre_in_frame", 32'(in_frame), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      check_reset("midrst");
      model_reset();
      snk_valid = 1'b0; snk_sop = 1'b0; snk_eop = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      idle();
      chk("midrst_post_stream_en", 32'(stream_en), 32'd1);
      chk("midrst_post_in_frame", 32'(in_frame), 32'd0);

      // ---- randomized traffic against the model ----
      for (int i = 0; i < 3000; i++) begin
         snk_valid = ($urandom_range(0, 9) < 7);
         snk_ready = ($urandom_range(0, 3) != 0) && (m_st != 2);
         snk_sop   = ($urandom_range(0, 99) < 18);
         snk_eop   = ($urandom_range(0, 99) < 25);
         if ($urandom_range(0, 19) == 0) cfg_ctrl[0] = ~cfg_ctrl[0];
         if ($urandom_range(0, 49) == 0) cfg_ctrl[1] = ~cfg_ctrl[1];
         if ($urandom_range(0, 2) == 0) begin
            cfg_effect = $urandom; cfg_key = $urandom; cfg_subst = $urandom;
         end
         irq_clr = ($urandom_range(0, 9) == 0);
         err_clr = ($urandom_range(0, 9) == 0);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/video_frame_ctrl.md
Name: video_frame_ctrl

Overview:
Frame-level sequencer for the video effects IP. It sits between the Avalon-MM register bank and the video effects datapath. It tracks frame boundaries on the Avalon-ST sink handshake and applies a new register configuration only between frames, so a frame is never processed with mixed settings. It also implements the pause request, end-of-frame interrupt, and frame-length and framing error detection.

Parameters:
FRAME_PIXELS, 76800, expected beats per frame (SOP to EOP inclusive), 320x240.
PIX_W, 17, width of the pixel counter; must satisfy 2^PIX_W > FRAME_PIXELS.
CNT_W, 16, width of the frame counter.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-low reset (0 = reset).
cfg_ctrl  in  32  reg0 shadow: [0] pause_req, [1] irq_enable.
cfg_effect  in  32  reg1 shadow: [4:0] effect, [9:8] delete_rgb, [17:16] quantif_level.
cfg_key  in  32  reg2 shadow: [31:16] color_key, [15:0] color_mask.
cfg_subst  in  32  reg3 shadow: [15:0] color_substitute.
irq_clr  in  1  one-cycle pulse; clears the pending interrupt.
err_clr  in  1  one-cycle pulse; clears err_len and err_sop.
snk_valid  in  1  sink valid_in as seen by the IP.
snk_ready  in  1  sink ready_out as driven by the IP.
snk_sop  in  1  startofpacket_in.
snk_eop  in  1  endofpacket_in.
stream_en  out  1  when 0, the top forces ready_out=0 and masks valid_out.
act_effect  out  5  frozen effect select.
act_delete_rgb  out  2  frozen delete_rgb.
act_quantif  out  2  frozen quantif_level.
act_color_key  out  16  frozen color_key.
act_color_mask  out  16  frozen color_mask.
act_color_subst  out  16  frozen color_substitute.
irq  out  1  level interrupt: pending AND cfg_ctrl[1].
paused  out  1  1 in state PAUSED.
in_frame  out  1  1 in state IN_FRAME.
frame_count  out  CNT_W  completed frames; wraps to 0 at the maximum value.
pix_count  out  PIX_W  beats accepted in the current frame.
err_len  out  1  sticky: last frame length differed from FRAME_PIXELS.
err_sop  out  1  sticky: framing error.

Behaviour:
- Beat definition: beat = snk_valid & snk_ready. Only beats advance any state.
- Reset (reset=0, asynchronous):
  - state = WAIT_SOP.
  - All act_* = 0, irq pending = 0, frame_count = 0, pix_count = 0, err_len = 0, err_sop = 0.
  - Outputs during and after reset: stream_en = 1, paused = 0, in_frame = 0.
- stream_en and paused are combinational decodes of the state. All other outputs are registered.
- Config load:
  - act_* <= cfg_* fields on every edge where the current state is not IN_FRAME, including the edge that leaves WAIT_SOP.
  - act_* are held constant throughout IN_FRAME.
  - Result: a frame uses the cfg values present in the cycle its SOP beat is accepted.
- State WAIT_SOP:
  - SOP beat with eop=0 -> IN_FRAME; pix_count <= 1.
  - SOP beat with eop=1 (single-beat frame) -> stay in WAIT_SOP; run the frame-end action with length 1.
  - Non-SOP beat -> err_sop <= 1; beat ignored; stay in WAIT_SOP.
  - No beat and pause_req=1 -> PAUSED.
  - A SOP beat in the same cycle as pause_req=1: the frame wins; the pause is taken at the next WAIT_SOP.
- State IN_FRAME:
  - Non-SOP, non-EOP beat -> pix_count + 1, saturating at 2^PIX_W-1.
  - EOP beat -> frame-end action; -> WAIT_SOP.
  - SOP beat (missing EOP) -> err_sop <= 1; pix_count <= 1; frame_count unchanged; stay IN_FRAME; act_* unchanged.
  - SOP and EOP on the same beat in IN_FRAME -> err_sop <= 1, then frame-end action with length 1.
  - pause_req is ignored in IN_FRAME.
- State PAUSED:
  - stream_en = 0, so no beats can occur.
  - pause_req=0 -> WAIT_SOP.
- Frame-end action (L = beats in the frame, including the EOP beat):
  - frame_count + 1.
  - err_len <= 1 if L != FRAME_PIXELS.
  - pending <= 1 if cfg_ctrl[1] = 1.
  - pix_count <= L. It holds until the next SOP beat.
- Clear priority: set beats clear.
  - frame-end in the same cycle as irq_clr leaves pending = 1.
  - An error event in the same cycle as err_clr leaves the flag = 1.
- Latency:
  - in_frame rises on the edge after the SOP beat is accepted.
  - irq rises on the edge after the EOP beat.
  - paused rises on the edge after pause_req is sampled in WAIT_SOP.
- Reset mid-frame: reset alone returns the block to WAIT_SOP; the partial frame is discarded and not counted.

Test Plan (bench uses FRAME_PIXELS=4):
- Normal frame, irq_enable=1, effect=5'h04: 4 beats (SOP..EOP) -> act_effect=04 from the cycle after the SOP beat; frame_count=1; pix_count=4; err_len=0; irq=1. Then irq_clr pulse -> irq=0.
- Config change mid-frame: cfg_effect goes 01 -> 10 after beat 2 -> act_effect stays 01 until EOP, then reads 10 on the next frame's SOP.
- pause_req=1 while IN_FRAME -> stream_en stays 1 until EOP. The next edge gives paused=1 and stream_en=0. pause_req=0 -> WAIT_SOP, stream_en=1.
- Short frame of 3 beats -> err_len=1, frame_count increments. err_clr and a second bad frame in the same cycle -> err_len stays 1.
- SOP at beat 3 with no EOP -> err_sop=1, pix_count=1, frame_count unchanged. A single SOP+EOP beat in WAIT_SOP -> frame_count+1 and err_len=1.
- Reset asserted mid-frame after 2 beats -> all outputs return to reset values asynchronously; stream_en=1 and in_frame=0 after release.
